// File: rtl/pixel_pkg.sv
// Pixel-domain constants and types shared by the input unpacker and the 8-bit output stage.
// Pure declarations; no logic.
package pixel_pkg;
    localparam int PIXEL_W   = 8;
    localparam int PIXEL_MAX = 255;
    localparam int PIXEL_MID = 128;

    typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/pixel_to_fixed_stream_if.sv
// Pixel-in / sample-out stream bundle; master is the upstream+downstream environment, slave is the unpacker.
// PRECISION must match the unpacker instance it connects to.
interface pixel_to_fixed_stream_if #(
    parameter int PRECISION = 16
);
    import pixel_pkg::*;

    pixel_t                        in_pixel;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [PRECISION-1:0]   out_sample;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_sol;
    logic                          out_eol;

    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_sample, out_valid, out_sol, out_eol
    );

    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_sample, out_valid, out_sol, out_eol
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered output (main) plus one overflow slot; 1-cycle latency.
// in_ready is a pure register (~skid_valid), so out_ready never reaches in_ready combinationally.
module skid_buffer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] main_data;
    logic         main_valid;
    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         accept;
    logic         main_free;

    assign accept    = in_valid & ~skid_valid;
    // Main can take new data when empty or when its current word leaves at this edge.
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_data  = main_data;
    assign out_valid = main_valid;
endmodule

// File: rtl/pixel_to_fixed_stream.sv
// Unpacks unsigned 8-bit pixels into signed PRECISION-bit fixed-point samples tagged with sol/eol; 1-cycle latency.
// Backpressure absorbed by a 2-entry skid buffer; in_ready is registered. Optional: PIXEL_CENTER_EN.
module pixel_to_fixed_stream
    import pixel_pkg::*;
#(
    parameter int PRECISION = 16,
    parameter int SHIFT     = 0,
    parameter int WIDTH     = 640
) (
    input  logic                      clk,
    input  logic                      reset,
    pixel_to_fixed_stream_if.slave    bus
);
    localparam int COL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
    localparam int PAY_W = PRECISION + 2;

    if (PRECISION < PIXEL_W + 1 + SHIFT) begin : g_bad_precision
        $error("pixel_to_fixed_stream: PRECISION must be >= 9 + SHIFT");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("pixel_to_fixed_stream: WIDTH must be >= 2");
    end
    if ($bits(bus.out_sample) != PRECISION) begin : g_bad_bus
        $error("pixel_to_fixed_stream: interface PRECISION mismatch");
    end

    logic                        accept;
    logic [COL_W-1:0]            col;
    logic signed [PRECISION-1:0] sample;
    logic                        sol;
    logic                        eol;
    logic [PAY_W-1:0]            pay_in;
    logic [PAY_W-1:0]            pay_out;
    logic                        buf_ready;

`ifdef PIXEL_CENTER_EN
    logic signed [PIXEL_W:0] centered;
    always_comb begin
        centered = $signed({1'b0, bus.in_pixel}) - $signed((PIXEL_W + 1)'(PIXEL_MID));
        sample   = PRECISION'(centered) <<< SHIFT;
    end
`else
    always_comb begin
        sample = $signed(PRECISION'(bus.in_pixel) << SHIFT);
    end
`endif

    assign accept = bus.in_valid & buf_ready;
    assign sol    = (col == '0);
    assign eol    = (col == LAST_COL);
    assign pay_in = {sol, eol, sample};

    // Column position of the next pixel to be accepted; reset abandons any partial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
        end else if (accept) begin
            col <= (col == LAST_COL) ? '0 : col + 1'b1;
        end
    end

    skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (pay_in),
        .in_valid  (bus.in_valid),
        .in_ready  (buf_ready),
        .out_data  (pay_out),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign bus.in_ready   = buf_ready;
    assign bus.out_sol    = pay_out[PAY_W-1];
    assign bus.out_eol    = pay_out[PAY_W-2];
    assign bus.out_sample = $signed(pay_out[PRECISION-1:0]);
endmodule

// File: tb/tb_pixel_to_fixed_stream.sv
// Bench for pixel_to_fixed_stream: directed table, hand-written stall/reset sequences and randomized
// traffic checked against a queue-based reference model.
module tb_pixel_to_fixed_stream;
    localparam int PREC  = 16;
    localparam int WIDTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_to_fixed_stream_if #(.PRECISION(PREC)) bus0 ();
    pixel_to_fixed_stream_if #(.PRECISION(PREC)) bus4 ();

    assign bus0.in_pixel  = in_pixel;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus4.in_pixel  = in_pixel;
    assign bus4.in_valid  = in_valid;
    assign bus4.out_ready = out_ready;

    pixel_to_fixed_stream #(.PRECISION(PREC), .SHIFT(0), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .bus(bus0));
    pixel_to_fixed_stream #(.PRECISION(PREC), .SHIFT(4), .WIDTH(WIDTH)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        int pix;
        bit use4;
        int exp;
    } vec_t;

    typedef struct {
        int  sample;
        bit  sol;
        bit  eol;
    } exp_t;

    exp_t q[$];
    int   mcol;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int model(input int pix, input int sh);
`ifdef PIXEL_CENTER_EN
        return (pix - 128) * (1 << sh);
`else
        return pix * (1 << sh);
`endif
    endfunction

    function automatic int s0();
        return int'($signed(bus0.out_sample));
    endfunction

    vec_t tbl[6];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_pixel  = 8'd77;
        out_ready = 1'b1;

        // Reset held with a valid input present: nothing may be captured.
        tick();
        tick();
        check("rst_out_valid", int'(bus0.out_valid), 0);
        check("rst_out_sample", s0(), 0);
        check("rst_out_sol", int'(bus0.out_sol), 0);
        check("rst_out_eol", int'(bus0.out_eol), 0);
        check("rst_in_ready", int'(bus0.in_ready), 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst_discarded", int'(bus0.out_valid), 0);

`ifdef PIXEL_CENTER_EN
        tbl[0] = '{50, 1'b0, -78};
        tbl[1] = '{0, 1'b0, -128};
        tbl[2] = '{255, 1'b0, 127};
        tbl[3] = '{128, 1'b0, 0};
        tbl[4] = '{255, 1'b1, 2032};
        tbl[5] = '{0, 1'b1, -2048};
`else
        tbl[0] = '{50, 1'b0, 50};
        tbl[1] = '{0, 1'b0, 0};
        tbl[2] = '{255, 1'b0, 255};
        tbl[3] = '{128, 1'b0, 128};
        tbl[4] = '{255, 1'b1, 4080};
        tbl[5] = '{0, 1'b1, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(tbl[i].pix);
            tick();
            in_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i),
                  int'(tbl[i].use4 ? bus4.out_valid : bus0.out_valid), 1);
            check($sformatf("tbl%0d_sample", i),
                  tbl[i].use4 ? int'($signed(bus4.out_sample)) : s0(), tbl[i].exp);
            tick();
        end

        // Line flags over two lines of WIDTH=4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(i);
            tick();
            check($sformatf("flag%0d_sample", i), s0(), model(i, 0));
            check($sformatf("flag%0d_sol", i), int'(bus0.out_sol), int'(i == 1 || i == 5));
            check($sformatf("flag%0d_eol", i), int'(bus0.out_eol), int'(i == 4 || i == 8));
        end
        in_valid = 1'b0;
        tick();

        // Reset mid-line: partial line abandoned, next pixel starts a new line.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(3 + i);
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("midrst_valid_during", int'(bus0.out_valid), 0);
        reset = 1'b0;
        tick();
        check("midrst_valid_after", int'(bus0.out_valid), 0);
        in_valid = 1'b1;
        in_pixel = 8'd9;
        tick();
        in_valid = 1'b0;
        check("midrst_valid9", int'(bus0.out_valid), 1);
        check("midrst_sample9", s0(), model(9, 0));
        check("midrst_sol9", int'(bus0.out_sol), 1);
        tick();

        // Backpressure: 10 and 20 captured, 30 held until release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'd10;
        tick();
        check("bp_ready_after10", int'(bus0.in_ready), 1);
        check("bp_sample10", s0(), model(10, 0));
        in_pixel = 8'd20;
        tick();
        check("bp_ready_after20", int'(bus0.in_ready), 0);
        in_pixel = 8'd30;
        tick();
        tick();
        check("bp_ready_held", int'(bus0.in_ready), 0);
        check("bp_hold_valid", int'(bus0.out_valid), 1);
        check("bp_hold_sample", s0(), model(10, 0));
        out_ready = 1'b1;
        tick();
        check("bp_rel_valid20", int'(bus0.out_valid), 1);
        check("bp_rel_sample20", s0(), model(20, 0));
        check("bp_rel_ready", int'(bus0.in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_rel_valid30", int'(bus0.out_valid), 1);
        check("bp_rel_sample30", s0(), model(30, 0));
        tick();
        check("bp_empty", int'(bus0.out_valid), 0);

        // Randomized traffic against the queue model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        mcol = 0;
        begin
            bit acc = 1'b0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                tick();
                check("rnd_in_ready", int'(bus0.in_ready), int'(q.size() < 2));
                check("rnd_out_valid", int'(bus0.out_valid), int'(q.size() > 0));
                if (bus0.out_valid && q.size() > 0) begin
                    check("rnd_sample", s0(), q[0].sample);
                    check("rnd_sol", int'(bus0.out_sol), int'(q[0].sol));
                    check("rnd_eol", int'(bus0.out_eol), int'(q[0].eol));
                end
                out_ready = ($urandom_range(0, 2) != 0);
                if (bus0.out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (acc || !in_valid) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_pixel = 8'($urandom_range(0, 255));
                end
                acc = in_valid && bus0.in_ready;
                if (acc) begin
                    q.push_back('{model(int'(in_pixel), 0), mcol == 0, mcol == WIDTH - 1});
                    mcol = (mcol + 1) % WIDTH;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (bus0.out_valid && q.size() > 0) begin
                check("drain_sample", s0(), q[0].sample);
                void'(q.pop_front());
            end
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_out_valid", int'(bus0.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
